// File: rtl/clock_32.sv
// Power-on reset generator: holds rst high for RESET_CYCLES rising clk edges
// after configuration, then releases it once and never re-asserts it.
module clock_32 #(
    parameter int RESET_CYCLES = 32,
    localparam int CNT_W = $clog2(RESET_CYCLES + 1)
) (
    input  logic clk,
    output logic rst
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(RESET_CYCLES);

    // There is no reset input, so the power-up state lives in the register
    // initialisers loaded by the bitstream (or at simulation time 0).
    logic [CNT_W-1:0] counter_reg = '0;
    logic             rst_reg     = 1'b1;

    logic [CNT_W-1:0] counter_next;
    logic             rst_next;

    // Counter saturates at LIMIT, which freezes the whole block after release.
    always_comb begin
        counter_next = counter_reg;
        if (counter_reg < LIMIT) begin
            counter_next = counter_reg + CNT_W'(1);
        end
        rst_next = (counter_next < LIMIT);
    end

    always_ff @(posedge clk) begin
        counter_reg <= counter_next;
        rst_reg     <= rst_next;
    end

    // Driven straight from a flop so downstream logic sees one clean 1->0 edge.
    assign rst = rst_reg;

endmodule

// File: tb/tb_clock_32.sv
// Scoreboarded bench for clock_32: five instances with different reset lengths
// and clock schedules (long run, idle start, pauses), each checked every edge.
module tb_clock_32;

    localparam int NDUT = 5;
    localparam int RC [NDUT] = '{32, 32, 32, 1, 100};

    logic clk_w [NDUT] = '{default: 1'b0};
    logic rst_w [NDUT];
    bit   exp_q [NDUT][$];
    int   rises [NDUT] = '{default: 0};
    int   checks = 0;
    int   errors = 0;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            clock_32 #(.RESET_CYCLES(RC[gi])) u_dut (
                .clk (clk_w[gi]),
                .rst (rst_w[gi])
            );

            // Monitor: after every rising edge pop the expected level and compare.
            initial begin : mon
                logic e;
                logic prev;
                int   edge_n;
                prev   = 1'b1;
                edge_n = 0;
                forever begin
                    @(posedge clk_w[gi]);
                    #1;
                    edge_n++;
                    checks++;
                    if (exp_q[gi].size() == 0) begin
                        errors++;
                        $display("FAIL dut%0d_edge%0d: unexpected edge, rst=%b, no expectation queued",
                                 gi, edge_n, rst_w[gi]);
                    end else begin
                        e = exp_q[gi].pop_front();
                        if (rst_w[gi] !== e) begin
                            errors++;
                            $display("FAIL dut%0d_edge%0d: rst=%b required %b", gi, edge_n, rst_w[gi], e);
                        end else begin
                            $display("dut%0d edge %0d t=%0t rst=%b ok", gi, edge_n, $time, rst_w[gi]);
                        end
                    end
                    if (prev === 1'b0 && rst_w[gi] !== 1'b0) rises[gi]++;
                    prev = rst_w[gi];
                end
            end
        end
    endgenerate

    // Reference model: rst after the k-th rising edge is 1 exactly when k < RC.
    task automatic drive(input int i, input int rc, input int idle_ns, input int n_edges,
                         input int pause_after, input int pause_ns);
        if (idle_ns > 0) begin
            #(idle_ns);
            checks++;
            if (rst_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL dut%0d_idle: rst=%b required 1 while clk idle", i, rst_w[i]);
            end else begin
                $display("dut%0d idle %0d ns rst=1 ok", i, idle_ns);
            end
        end
        for (int k = 1; k <= n_edges; k++) begin
            #10;
            exp_q[i].push_back(k < rc);
            clk_w[i] = 1'b1;
            #10;
            clk_w[i] = 1'b0;
            if (k == pause_after) #(pause_ns);
        end
    endtask

    initial begin : t1_check
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (rst_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL dut%0d_power_up: rst=%b required 1", i, rst_w[i]);
            end else begin
                $display("dut%0d power-up rst=1 ok", i);
            end
        end
    end

    initial begin : main
        int pa3, pn3, pa4, pn4;
        pa3 = $urandom_range(1, 4);
        pn3 = $urandom_range(1, 30) * 20;
        pa4 = $urandom_range(1, 109);
        pn4 = $urandom_range(1, 40) * 20;
        $display("random pauses: dut3 after edge %0d for %0d ns, dut4 after edge %0d for %0d ns",
                 pa3, pn3, pa4, pn4);
        fork
            drive(0, RC[0], 0,    RC[0] + 10000, 0,   0);
            drive(1, RC[1], 1000, 40,            0,   0);
            drive(2, RC[2], 0,    40,            10,  500);
            drive(3, RC[3], 0,    5,             pa3, pn3);
            drive(4, RC[4], 0,    110,           pa4, pn4);
        join
        #50;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL dut%0d_drain: %0d expectations left, required 0", i, exp_q[i].size());
            end
            checks++;
            if (rises[i] != 0) begin
                errors++;
                $display("FAIL dut%0d_reassert: %0d 0->1 transitions, required 0", i, rises[i]);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
